// File: rtl/cmp_branch_resolver.sv
// cmp_branch_resolver: slice-serial operand compare and branch resolution; CMP_SIGNED_EN adds a two's-complement mode via is_signed
module cmp_branch_resolver #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4,
  parameter int PC_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
  input  logic [2:0]       cond,
  input  logic [PC_W-1:0]  target,
`ifdef CMP_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             taken,
  output logic [PC_W-1:0]  br_target,
  output logic             a_less,
  output logic             a_greater,
  output logic             equal
);
  localparam int N  = WIDTH / SLICE;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [2:0]        cond_q;
  logic [PC_W-1:0]   tgt_q;
  logic [IW-1:0]     idx_q;
  logic              lt_q, gt_q, eq_q, taken_q;
  logic [SLICE-1:0]  sl_a [N];
  logic [SLICE-1:0]  sl_b [N];
  logic [SLICE-1:0]  cur_a, cur_b;
  logic              flip, lt, gt, eq, fin, taken_d;
  logic [7:0]        tv;
  for (genvar g = 0; g < N; g++) begin : g_sl
    assign sl_a[g] = a_q[g*SLICE +: SLICE];
    assign sl_b[g] = b_q[g*SLICE +: SLICE];
  end
`ifdef CMP_SIGNED_EN
  logic sgn_q;
  always_ff @(posedge clk)
    sgn_q <= rst ? 1'b0 : (req_valid && req_ready) ? is_signed : sgn_q;
  assign flip = sgn_q && idx_q == IW'(N-1);
`else
  assign flip = 1'b0;
`endif
  // slice compare, the top slice optionally sign-flipped, and condition evaluation on the fresh flags
  always_comb begin
    cur_a   = sl_a[idx_q] ^ (SLICE'(flip) << (SLICE-1));
    cur_b   = sl_b[idx_q] ^ (SLICE'(flip) << (SLICE-1));
    lt      = cur_a < cur_b;
    gt      = cur_a > cur_b;
    eq      = !lt && !gt;
    fin     = state_q == SCAN && (lt || gt || idx_q == '0);
    tv      = {1'b0, 1'b1, gt | eq, lt | eq, gt, lt, !eq, eq};
    taken_d = tv[cond_q];
  end
  // state register
  always_ff @(posedge clk)
    state_q <= rst ? IDLE : state_d;
  // next state: accept, early or final exit, and handshake release
  always_comb
    state_d = (state_q == IDLE && req_valid) ? SCAN :
              fin                           ? DONE :
              (state_q == DONE && resp_ready) ? IDLE : state_q;
  // outputs: handshake from state, results from registers
  always_comb begin
    req_ready  = state_q == IDLE;
    resp_valid = state_q == DONE;
    taken      = taken_q;
    br_target  = tgt_q;
    a_less     = lt_q;
    a_greater  = gt_q;
    equal      = eq_q;
  end
  // request latch, slice index walk and flag/taken update at completion
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      cond_q  <= '0;
      tgt_q   <= '0;
      idx_q   <= '0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      taken_q <= 1'b0;
    end else if (req_valid && req_ready) begin
      a_q    <= inp1;
      b_q    <= inp2;
      cond_q <= cond;
      tgt_q  <= target;
      idx_q  <= IW'(N-1);
    end else if (fin) begin
      lt_q    <= lt;
      gt_q    <= gt;
      eq_q    <= eq;
      taken_q <= taken_d;
    end else if (state_q == SCAN) begin
      idx_q <= idx_q - 1'b1;
    end
  end
endmodule
